task_manager: RTL and testbench

TASK_MANAGER -- requirements
Module: task_manager

---
 rtl/task_manager_pkg.sv | 14 +
 rtl/task_manager_buf.sv | 22 ++
 rtl/task_manager.sv | 121 ++++++++++++
 tb/tb_task_manager.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/task_manager_pkg.sv
// Shared types and constants for the packet task manager.
package task_manager_pkg;
  localparam int MAX_BYTES_DEF = 64;
  localparam int BYTE_W        = 8;
  localparam int SIZE_W        = 12;
  localparam int CSUM_W        = 16;

  typedef enum logic [2:0] {IDLE, LOAD, READY, SEND, RECV, DONE} state_e;

  // Answer byte counter saturates rather than wrapping.
  function automatic logic [SIZE_W-1:0] sat_inc(input logic [SIZE_W-1:0] v);
    return (&v) ? v : v + SIZE_W'(1);
  endfunction
endpackage

// File: rtl/task_manager_buf.sv
// Packet byte store: synchronous write port, asynchronous read port.
module task_manager_buf
  import task_manager_pkg::*;
#(
  parameter int DEPTH = MAX_BYTES_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [BYTE_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [BYTE_W-1:0] o_rdata
);
  logic [BYTE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];
endmodule

// File: rtl/task_manager.sv
// Loads a packet, streams it to a task block, then collects and checks the answer.
module task_manager
  import task_manager_pkg::*;
#(
  parameter int MAX_BYTES = MAX_BYTES_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_valid,
  input  logic [BYTE_W-1:0] i_load_data,
  input  logic              i_load_last,
  output logic              o_load_ready,
  input  logic              i_start,
  input  logic              i_clear,
  output logic [BYTE_W-1:0] o_tdata,
  output logic              o_tdata_valid,
  output logic              o_tdata_last,
  input  logic              i_tready,
  output logic              o_tmanager_ready,
  input  logic              i_tanswer_ready,
  input  logic [BYTE_W-1:0] i_tanswer_data,
  input  logic              i_tanswer_data_last,
  input  logic [SIZE_W-1:0] i_packet_size_in_bytes,
  output logic              o_done,
  output logic              o_size_err,
  output logic [SIZE_W-1:0] o_rx_count,
  output logic [CSUM_W-1:0] o_rx_checksum
);
  localparam int AW = $clog2(MAX_BYTES);
  localparam int LW = AW + 1;  // tx_len must hold MAX_BYTES itself
  localparam logic [AW-1:0] LAST_ADDR = AW'(MAX_BYTES - 1);

  state_e            state_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     tx_len_q;
  logic [SIZE_W-1:0] rx_count_q, rx_count_d;
  logic [CSUM_W-1:0] rx_csum_q, rx_csum_d;
  logic              size_err_q;
  logic              load_en, beat_last;
  logic [BYTE_W-1:0] rd_data;

  task_manager_buf #(.DEPTH(MAX_BYTES)) u_buf (
    .i_clk   (i_clk),
    .i_we    (load_en),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_load_data),
    .i_raddr (rd_ptr_q),
    .o_rdata (rd_data)
  );

  // Every output is a decode of registered state; no input reaches an output.
  assign o_load_ready     = (state_q == IDLE) || (state_q == LOAD);
  assign o_tdata_valid    = (state_q == SEND);
  assign o_tdata          = o_tdata_valid ? rd_data : '0;
  assign beat_last        = ({1'b0, rd_ptr_q} == tx_len_q - LW'(1));
  assign o_tdata_last     = o_tdata_valid && beat_last;
  assign o_tmanager_ready = (state_q == RECV);
  assign o_done           = (state_q == DONE);
  assign o_size_err       = size_err_q;
  assign o_rx_count       = rx_count_q;
  assign o_rx_checksum    = rx_csum_q;

  assign load_en    = i_load_valid && o_load_ready;
  assign rx_count_d = sat_inc(rx_count_q);
  assign rx_csum_d  = rx_csum_q + CSUM_W'(i_tanswer_data);

  always_ff @(posedge i_clk) begin
    if (!i_rst || i_clear) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_len_q   <= '0;
      rx_count_q <= '0;
      rx_csum_q  <= '0;
      size_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, LOAD: begin
          if (load_en) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            state_q  <= LOAD;
            if (i_load_last || wr_ptr_q == LAST_ADDR) begin
              tx_len_q <= {1'b0, wr_ptr_q} + LW'(1);
              state_q  <= READY;
            end
          end
        end
        READY, DONE: begin
          if (i_start) begin
            state_q    <= SEND;
            rd_ptr_q   <= '0;
            rx_count_q <= '0;
            rx_csum_q  <= '0;
            size_err_q <= 1'b0;
          end
        end
        SEND: begin
          if (i_tready) begin
            if (beat_last) begin
              state_q  <= RECV;
              rd_ptr_q <= '0;
            end else begin
              rd_ptr_q <= rd_ptr_q + AW'(1);
            end
          end
        end
        RECV: begin
          if (i_tanswer_ready) begin
            rx_count_q <= rx_count_d;
            rx_csum_q  <= rx_csum_d;
            if (i_tanswer_data_last) begin
              size_err_q <= (rx_count_d != i_packet_size_in_bytes);
              state_q    <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_task_manager.sv
// Directed-vector bench for task_manager.
module tb_task_manager;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_load_valid, i_load_last;
  logic [7:0]  i_load_data;
  logic        o_load_ready;
  logic        i_start, i_clear;
  logic [7:0]  o_tdata;
  logic        o_tdata_valid, o_tdata_last;
  logic        i_tready;
  logic        o_tmanager_ready;
  logic        i_tanswer_ready, i_tanswer_data_last;
  logic [7:0]  i_tanswer_data;
  logic [11:0] i_packet_size_in_bytes;
  logic        o_done, o_size_err;
  logic [11:0] o_rx_count;
  logic [15:0] o_rx_checksum;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_buf [64];

  task_manager #(.MAX_BYTES(64)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_load_valid(i_load_valid), .i_load_data(i_load_data), .i_load_last(i_load_last),
    .o_load_ready(o_load_ready), .i_start(i_start), .i_clear(i_clear),
    .o_tdata(o_tdata), .o_tdata_valid(o_tdata_valid), .o_tdata_last(o_tdata_last),
    .i_tready(i_tready), .o_tmanager_ready(o_tmanager_ready),
    .i_tanswer_ready(i_tanswer_ready), .i_tanswer_data(i_tanswer_data),
    .i_tanswer_data_last(i_tanswer_data_last), .i_packet_size_in_bytes(i_packet_size_in_bytes),
    .o_done(o_done), .o_size_err(o_size_err), .o_rx_count(o_rx_count), .o_rx_checksum(o_rx_checksum)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic load_packet(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      i_load_valid = 1'b1;
      i_load_data  = tx_buf[i];
      i_load_last  = with_last && (i == n - 1);
      @(negedge i_clk);
    end
    i_load_valid = 1'b0;
    i_load_last  = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++; if (o_tdata_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", o_tdata_valid); end
    checks++; if (o_tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata got %h exp 00", o_tdata); end
    checks++; if (o_tmanager_ready !== 1'b0) begin errors++; $display("FAIL rst_tmready got %b exp 0", o_tmanager_ready); end
    checks++; if (o_done !== 1'b0 || o_size_err !== 1'b0) begin errors++; $display("FAIL rst_done_err got %b%b exp 00", o_done, o_size_err); end
    checks++; if (o_rx_count !== 12'd0 || o_rx_checksum !== 16'd0) begin errors++; $display("FAIL rst_counts got %0d/%h exp 0/0000", o_rx_count, o_rx_checksum); end
    i_rst = 1'b1;
    @(negedge i_clk);
    checks++; if (o_load_ready !== 1'b1) begin errors++; $display("FAIL rst_load_ready got %b exp 1", o_load_ready); end
    $display("test_reset complete");
  endtask

  task automatic test_start_ignored();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    checks++; if (o_tdata_valid !== 1'b0 || o_load_ready !== 1'b1) begin errors++; $display("FAIL idle_start got valid=%b lr=%b exp 0/1", o_tdata_valid, o_load_ready); end
    $display("test_start_ignored complete");
  endtask

  task automatic test_send_basic();
    for (int i = 0; i < 4; i++) tx_buf[i] = 8'(i + 1);
    load_packet(4, 1'b1);
    checks++; if (o_load_ready !== 1'b0 || o_tdata_valid !== 1'b0) begin errors++; $display("FAIL ready_state got lr=%b valid=%b exp 0/0", o_load_ready, o_tdata_valid); end
    i_tready = 1'b1;
    i_start  = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (o_tdata_valid !== 1'b1 || o_tdata !== 8'(i + 1) || o_tdata_last !== (i == 3))
        begin errors++; $display("FAIL basic_beat%0d got v=%b d=%h l=%b exp 1/%h/%b", i, o_tdata_valid, o_tdata, o_tdata_last, 8'(i + 1), (i == 3)); end
      @(negedge i_clk);
    end
    checks++; if (o_tmanager_ready !== 1'b1 || o_tdata_valid !== 1'b0) begin errors++; $display("FAIL basic_recv got tmr=%b v=%b exp 1/0", o_tmanager_ready, o_tdata_valid); end
    i_tready = 1'b0;
    $display("test_send_basic complete");
  endtask

  task automatic test_answer_ok();
    logic [7:0] ans [3];
    ans[0] = 8'h10; ans[1] = 8'h20; ans[2] = 8'h30;
    i_packet_size_in_bytes = 12'd3;
    for (int i = 0; i < 3; i++) begin
      i_tanswer_ready = 1'b1;
      i_tanswer_data  = ans[i];
      i_tanswer_data_last = (i == 2);
      @(negedge i_clk);
    end
    i_tanswer_ready = 1'b0; i_tanswer_data_last = 1'b0;
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL ok_done got %b exp 1", o_done); end
    checks++; if (o_rx_count !== 12'd3) begin errors++; $display("FAIL ok_count got %0d exp 3", o_rx_count); end
    checks++; if (o_rx_checksum !== 16'h0060) begin errors++; $display("FAIL ok_csum got %h exp 0060", o_rx_checksum); end
    checks++; if (o_size_err !== 1'b0 || o_tmanager_ready !== 1'b0) begin errors++; $display("FAIL ok_err got err=%b tmr=%b exp 0/0", o_size_err, o_tmanager_ready); end
    i_tanswer_ready = 1'b1; i_tanswer_data = 8'hFF; i_tanswer_data_last = 1'b1;
    @(negedge i_clk);
    i_tanswer_ready = 1'b0; i_tanswer_data_last = 1'b0;
    checks++; if (o_rx_count !== 12'd3 || o_rx_checksum !== 16'h0060) begin errors++; $display("FAIL done_hold got %0d/%h exp 3/0060", o_rx_count, o_rx_checksum); end
    $display("test_answer_ok complete");
  endtask

  task automatic test_stall();
    logic [5:0] pat = 6'b111001;
    int idx = 0;
    int cyc = 0;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    while (idx < 4 && cyc < 20) begin
      i_tready = (cyc < 6) ? pat[cyc] : 1'b1;
      i_tanswer_ready = 1'b1;
      i_tanswer_data  = 8'h55;
      checks++; if (o_tdata_valid !== 1'b1 || o_tdata !== tx_buf[idx] || o_tdata_last !== (idx == 3))
        begin errors++; $display("FAIL stall_cyc%0d got v=%b d=%h l=%b exp 1/%h/%b", cyc, o_tdata_valid, o_tdata, o_tdata_last, tx_buf[idx], (idx == 3)); end
      if (i_tready) idx++;
      @(negedge i_clk);
      cyc++;
    end
    i_tready = 1'b0; i_tanswer_ready = 1'b0;
    checks++; if (idx != 4) begin errors++; $display("FAIL stall_bound got %0d beats exp 4", idx); end
    checks++; if (o_tmanager_ready !== 1'b1 || o_rx_count !== 12'd0 || o_rx_checksum !== 16'd0)
      begin errors++; $display("FAIL stall_recv got tmr=%b cnt=%0d csum=%h exp 1/0/0000", o_tmanager_ready, o_rx_count, o_rx_checksum); end
    $display("test_stall complete");
  endtask

  task automatic test_size_err();
    i_packet_size_in_bytes = 12'd5;
    i_tanswer_ready = 1'b1; i_tanswer_data = 8'h05; i_tanswer_data_last = 1'b0;
    @(negedge i_clk);
    i_tanswer_data = 8'h07; i_tanswer_data_last = 1'b1;
    @(negedge i_clk);
    i_tanswer_ready = 1'b0; i_tanswer_data_last = 1'b0;
    checks++; if (o_done !== 1'b1 || o_size_err !== 1'b1) begin errors++; $display("FAIL err_flags got done=%b err=%b exp 1/1", o_done, o_size_err); end
    checks++; if (o_rx_count !== 12'd2 || o_rx_checksum !== 16'h000C) begin errors++; $display("FAIL err_counts got %0d/%h exp 2/000c", o_rx_count, o_rx_checksum); end
    $display("test_size_err complete");
  endtask

  task automatic test_max();
    i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
    checks++; if (o_done !== 1'b0 || o_rx_count !== 12'd0 || o_size_err !== 1'b0 || o_load_ready !== 1'b1)
      begin errors++; $display("FAIL clear_state got done=%b cnt=%0d err=%b lr=%b exp 0/0/0/1", o_done, o_rx_count, o_size_err, o_load_ready); end
    for (int i = 0; i < 64; i++) tx_buf[i] = 8'(i * 3 + 1);
    load_packet(63, 1'b0);
    checks++; if (o_load_ready !== 1'b1) begin errors++; $display("FAIL max_63 got lr=%b exp 1", o_load_ready); end
    i_load_valid = 1'b1; i_load_data = tx_buf[63];
    @(negedge i_clk);
    i_load_data = 8'hAA;
    @(negedge i_clk);
    i_load_valid = 1'b0;
    checks++; if (o_load_ready !== 1'b0) begin errors++; $display("FAIL max_64 got lr=%b exp 0", o_load_ready); end
    i_tready = 1'b1; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      checks++; if (o_tdata_valid !== 1'b1 || o_tdata !== tx_buf[i] || o_tdata_last !== (i == 63))
        begin errors++; $display("FAIL max_beat%0d got v=%b d=%h l=%b exp 1/%h/%b", i, o_tdata_valid, o_tdata, o_tdata_last, tx_buf[i], (i == 63)); end
      @(negedge i_clk);
    end
    i_tready = 1'b0;
    checks++; if (o_tmanager_ready !== 1'b1) begin errors++; $display("FAIL max_recv got %b exp 1", o_tmanager_ready); end
    i_packet_size_in_bytes = 12'd1;
    i_tanswer_ready = 1'b1; i_tanswer_data = 8'h42; i_tanswer_data_last = 1'b1;
    @(negedge i_clk);
    i_tanswer_ready = 1'b0; i_tanswer_data_last = 1'b0;
    checks++; if (o_done !== 1'b1 || o_rx_count !== 12'd1 || o_rx_checksum !== 16'h0042 || o_size_err !== 1'b0)
      begin errors++; $display("FAIL max_done got done=%b cnt=%0d csum=%h err=%b exp 1/1/0042/0", o_done, o_rx_count, o_rx_checksum, o_size_err); end
    $display("test_max complete");
  endtask

  task automatic test_clear_reset();
    i_clear = 1'b1; i_start = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0; i_start = 1'b0;
    checks++; if (o_tdata_valid !== 1'b0 || o_load_ready !== 1'b1 || o_done !== 1'b0 || o_rx_count !== 12'd0)
      begin errors++; $display("FAIL clear_start got v=%b lr=%b done=%b cnt=%0d exp 0/1/0/0", o_tdata_valid, o_load_ready, o_done, o_rx_count); end
    tx_buf[0] = 8'hC3; tx_buf[1] = 8'h3C;
    load_packet(2, 1'b1);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    checks++; if (o_tdata_valid !== 1'b1 || o_tdata !== 8'hC3) begin errors++; $display("FAIL rsend got v=%b d=%h exp 1/c3", o_tdata_valid, o_tdata); end
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++; if (o_tdata_valid !== 1'b0 || o_tdata !== 8'h00 || o_tdata_last !== 1'b0 || o_tmanager_ready !== 1'b0)
      begin errors++; $display("FAIL midsend_rst got v=%b d=%h l=%b tmr=%b exp 0/00/0/0", o_tdata_valid, o_tdata, o_tdata_last, o_tmanager_ready); end
    checks++; if (o_done !== 1'b0 || o_size_err !== 1'b0 || o_rx_count !== 12'd0 || o_rx_checksum !== 16'd0)
      begin errors++; $display("FAIL midsend_res got done=%b err=%b cnt=%0d csum=%h exp 0/0/0/0000", o_done, o_size_err, o_rx_count, o_rx_checksum); end
    i_rst = 1'b1;
    @(negedge i_clk);
    checks++; if (o_load_ready !== 1'b1) begin errors++; $display("FAIL post_rst_lr got %b exp 1", o_load_ready); end
    $display("test_clear_reset complete");
  endtask

  initial begin
    i_rst = 1'b0; i_load_valid = 1'b0; i_load_data = 8'h00; i_load_last = 1'b0;
    i_start = 1'b0; i_clear = 1'b0; i_tready = 1'b0;
    i_tanswer_ready = 1'b0; i_tanswer_data = 8'h00; i_tanswer_data_last = 1'b0;
    i_packet_size_in_bytes = 12'd0;
    test_reset();
    test_start_ignored();
    test_send_basic();
    test_answer_ok();
    test_stall();
    test_size_err();
    test_max();
    test_clear_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
